// File: rtl/spinv_pipe.sv
// spinv_pipe: elastic dual-rail pipeline with per-stage optional rail inversion.
//
// Carries WIDTH dual-rail pairs through DEPTH registered stages with a
// valid/ready handshake. Stage k inverts both rails when INV_MASK[k] is set,
// which flips both the logic value and the spacer polarity. Incoming words are
// classified as complete, spacer or malformed. Only complete words enter the
// pipe. Spacers are swallowed. Malformed words are swallowed and raise the
// sticky err flag. While no word is presented, the outputs show the output
// spacer OUT_SP.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   in_t, in_f          input true/false rails
//   in_valid, in_ready  input handshake
//   out_t, out_f        output true/false rails (OUT_SP spacer when idle)
//   out_valid, out_ready output handshake
//   err                 sticky malformed-input flag
//   drop_cnt            saturating count of malformed words consumed
//                       (present only when SPINV_PIPE_STAT_EN is defined)
//
// Optional feature macro: SPINV_PIPE_STAT_EN
module spinv_pipe #(
  parameter int unsigned      WIDTH    = 8,
  parameter int unsigned      DEPTH    = 2,
  parameter logic [DEPTH-1:0] INV_MASK = '1,
  parameter logic             IN_SP    = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_t,
  input  logic [WIDTH-1:0] in_f,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_t,
  output logic [WIDTH-1:0] out_f,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             err
`ifdef SPINV_PIPE_STAT_EN
  ,
  output logic [7:0]       drop_cnt
`endif
);

  localparam logic OUT_SP = IN_SP ^ (^INV_MASK);

  // Spacer polarity held by stage k: the input polarity flipped by every
  // inverting stage up to and including k.
  function automatic logic stage_sp(input int unsigned k);
    logic s;
    s = IN_SP;
    for (int unsigned j = 0; j < DEPTH; j++) begin
      if (j <= k) s = s ^ INV_MASK[j];
    end
    return s;
  endfunction

  logic [WIDTH-1:0] t_q [DEPTH];
  logic [WIDTH-1:0] f_q [DEPTH];
  logic [DEPTH-1:0] v_q, v_d;
  logic             err_q, err_d;

  logic [DEPTH-1:0] leave;  // stage k contents move on this cycle
  logic [DEPTH-1:0] ld;     // stage k captures new contents this cycle

  logic [WIDTH-1:0] code_vec, sp_vec;
  logic             w_complete, w_spacer, w_malformed, in_fire;

  // Word classification.
  always_comb begin
    code_vec    = in_t ^ in_f;
    sp_vec      = ~(in_t ^ {WIDTH{IN_SP}}) & ~(in_f ^ {WIDTH{IN_SP}});
    w_complete  = &code_vec;
    w_spacer    = &sp_vec;
    w_malformed = !w_complete && !w_spacer;
  end

  // Ready propagates backwards from out_ready. A stage leaves when the next
  // stage is empty or is itself leaving. This chain is combinational end to
  // end, so a full pipe still accepts a word when out_ready is high.
  always_comb begin
    int unsigned k;
    k        = 0;
    leave    = '0;
    ld       = '0;
    leave[DEPTH-1] = v_q[DEPTH-1] && out_ready;
    for (int unsigned j = 1; j < DEPTH; j++) begin
      k        = DEPTH - 1 - j;
      leave[k] = v_q[k] && (!v_q[k+1] || leave[k+1]);
    end
    in_ready = !v_q[0] || leave[0];
    in_fire  = in_valid && in_ready;
    ld[0]    = in_fire && w_complete;
    for (int unsigned m = 1; m < DEPTH; m++) begin
      ld[m] = v_q[m-1] && (!v_q[m] || leave[m]);
    end
    v_d   = ld | (v_q & ~leave);
    err_d = err_q || (in_fire && w_malformed);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q   <= '0;
      err_q <= 1'b0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        t_q[k] <= {WIDTH{stage_sp(k)}};
        f_q[k] <= {WIDTH{stage_sp(k)}};
      end
    end else begin
      v_q   <= v_d;
      err_q <= err_d;
      if (ld[0]) begin
        t_q[0] <= in_t ^ {WIDTH{INV_MASK[0]}};
        f_q[0] <= in_f ^ {WIDTH{INV_MASK[0]}};
      end
      for (int unsigned k = 1; k < DEPTH; k++) begin
        if (ld[k]) begin
          t_q[k] <= t_q[k-1] ^ {WIDTH{INV_MASK[k]}};
          f_q[k] <= f_q[k-1] ^ {WIDTH{INV_MASK[k]}};
        end
      end
    end
  end

  // Idle output is muxed from the valid bit, so it shows the spacer as soon
  // as reset asserts.
  always_comb begin
    out_valid = v_q[DEPTH-1];
    out_t     = out_valid ? t_q[DEPTH-1] : {WIDTH{OUT_SP}};
    out_f     = out_valid ? f_q[DEPTH-1] : {WIDTH{OUT_SP}};
    err       = err_q;
  end

`ifdef SPINV_PIPE_STAT_EN
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (in_fire && w_malformed && (cnt_q != '1)) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign drop_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_spinv_pipe.sv
module tb_spinv_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in_t, in_f, out_t, out_f;
  logic       in_valid, in_ready, out_valid, out_ready, err;
  logic [3:0] b_in_t, b_in_f, b_out_t, b_out_f;
  logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_err;
`ifdef SPINV_PIPE_STAT_EN
  logic [7:0] drop_cnt, b_drop_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b[$];

  always #5 clk = ~clk;

  spinv_pipe #(.WIDTH(4), .DEPTH(2), .INV_MASK(2'b01), .IN_SP(1'b0)) dut (
    .clk(clk), .rst(rst), .in_t(in_t), .in_f(in_f), .in_valid(in_valid),
    .in_ready(in_ready), .out_t(out_t), .out_f(out_f), .out_valid(out_valid),
    .out_ready(out_ready), .err(err)
`ifdef SPINV_PIPE_STAT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  spinv_pipe #(.WIDTH(4), .DEPTH(2), .INV_MASK(2'b11), .IN_SP(1'b1)) dut_b (
    .clk(clk), .rst(rst), .in_t(b_in_t), .in_f(b_in_f), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .out_t(b_out_t), .out_f(b_out_f), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .err(b_err)
`ifdef SPINV_PIPE_STAT_EN
    , .drop_cnt(b_drop_cnt)
`endif
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitors: pop and compare on every output transfer.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("sb_a_unexpected", {out_t, out_f}, 8'hxx);
      else chk("sb_a_word", {out_t, out_f}, exp_q.pop_front());
    end
  end

  always @(negedge clk) begin
    if (!rst && b_out_valid && b_out_ready) begin
      if (exp_b.size() == 0) chk("sb_b_unexpected", {b_out_t, b_out_f}, 8'hxx);
      else chk("sb_b_word", {b_out_t, b_out_f}, exp_b.pop_front());
    end
  end

  // Present a word to dut, wait (bounded) for acceptance, optionally push
  // the expected output, then drop in_valid just after the transfer edge.
  task automatic send(input logic [3:0] t, input logic [3:0] f,
                      input bit push, input logic [7:0] expv);
    bit ok;
    ok = 1'b0;
    in_t = t; in_f = f; in_valid = 1'b1;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      ok = in_ready;
    end
    if (!ok) chk("send_timeout", 8'(in_ready), 8'h01);
    if (push) exp_q.push_back(expv);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_t = '0; in_f = '0; in_valid = 1'b0; out_ready = 1'b1;
    b_in_t = '1; b_in_f = '1; b_in_valid = 1'b0; b_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Idle after reset
    chk("idle_valid", 8'(out_valid), 8'h00);
    chk("idle_rails", {out_t, out_f}, 8'hFF);
    chk("idle_err", 8'(err), 8'h00);
    chk("idle_ready", 8'(in_ready), 8'h01);

    // Single word, latency DEPTH
    @(posedge clk); #1;
    send(4'b1010, 4'b0101, 1'b1, {4'b0101, 4'b1010});
    @(negedge clk);
    chk("lat_early", 8'(out_valid), 8'h00);
    @(negedge clk);
    chk("lat_valid", 8'(out_valid), 8'h01);
    @(negedge clk);
    chk("after_word_valid", 8'(out_valid), 8'h00);
    chk("after_word_rails", {out_t, out_f}, 8'hFF);

    // Backpressure: two words fill the pipe
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(4'b0001, 4'b1110, 1'b1, {4'b1110, 4'b0001});
    send(4'b0110, 4'b1001, 1'b1, {4'b1001, 4'b0110});
    in_t = 4'b1111; in_f = 4'b0000; in_valid = 1'b1;
    @(negedge clk);
    chk("bp_full_ready", 8'(in_ready), 8'h00);
    chk("bp_hold", {out_t, out_f}, {4'b1110, 4'b0001});
    // Malformed word against a full, stalled pipe is not consumed
    @(posedge clk); #1;
    in_t = 4'b1100; in_f = 4'b0100;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_mal_ready", 8'(in_ready), 8'h00);
    chk("bp_mal_err", 8'(err), 8'h00);
`ifdef SPINV_PIPE_STAT_EN
    chk("bp_mal_cnt", drop_cnt, 8'd0);
`endif
    chk("bp_hold2", {out_t, out_f}, {4'b1110, 4'b0001});
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    send(4'b1111, 4'b0000, 1'b1, {4'b0000, 4'b1111});
    repeat (4) @(negedge clk);
    chk("bp_drained", 8'(exp_q.size()), 8'h00);

    // Spacer then malformed
    @(posedge clk); #1;
    send(4'b0000, 4'b0000, 1'b0, 8'h00);
    repeat (3) @(negedge clk);
    chk("spacer_valid", 8'(out_valid), 8'h00);
    chk("spacer_err", 8'(err), 8'h00);
    @(posedge clk); #1;
    send(4'b1100, 4'b0100, 1'b0, 8'h00);
    @(negedge clk);
    chk("mal_err", 8'(err), 8'h01);
    repeat (3) @(negedge clk);
    chk("mal_err_sticky", 8'(err), 8'h01);
    chk("mal_valid", 8'(out_valid), 8'h00);
`ifdef SPINV_PIPE_STAT_EN
    chk("mal_cnt", drop_cnt, 8'd1);
`endif

    // Mid-operation asynchronous reset with two words buffered
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(4'b0011, 4'b1100, 1'b0, 8'h00);
    send(4'b0101, 4'b1010, 1'b0, 8'h00);
    @(negedge clk);
    chk("pre_rst_valid", 8'(out_valid), 8'h01);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_valid", 8'(out_valid), 8'h00);
    chk("rst_async_rails", {out_t, out_f}, 8'hFF);
    chk("rst_async_err", 8'(err), 8'h00);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_valid", 8'(out_valid), 8'h00);
    chk("post_rst_ready", 8'(in_ready), 8'h01);
    chk("post_rst_err", 8'(err), 8'h00);
`ifdef SPINV_PIPE_STAT_EN
    chk("post_rst_cnt", drop_cnt, 8'd0);
`endif

    // Second configuration: both stages invert, all-one input spacer
    chk("b_idle_rails", {b_out_t, b_out_f}, 8'hFF);
    chk("b_idle_valid", 8'(b_out_valid), 8'h00);
    @(posedge clk); #1;
    b_in_t = 4'b0011; b_in_f = 4'b1100; b_in_valid = 1'b1;
    begin
      bit ok;
      ok = 1'b0;
      for (int c = 0; c < 50 && !ok; c++) begin
        @(negedge clk);
        ok = b_in_ready;
      end
      if (!ok) chk("b_send_timeout", 8'(b_in_ready), 8'h01);
    end
    exp_b.push_back({4'b0011, 4'b1100});
    @(posedge clk); #1;
    b_in_valid = 1'b0; b_in_t = '1; b_in_f = '1;
    begin
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
        @(negedge clk);
        seen = b_out_valid;
      end
      chk("b_out_seen", 8'(seen), 8'h01);
    end
    repeat (2) @(negedge clk);
    chk("b_drained", 8'(exp_b.size()), 8'h00);
    chk("b_err", 8'(b_err), 8'h00);
    chk("a_drained_final", 8'(exp_q.size()), 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spinv_pipe.md
Name: spinv_pipe

Overview:
Parametrised, clocked successor to the single-bit spacer-inverter cells. Carries WIDTH dual-rail bits through DEPTH registered stages with a valid/ready handshake. Each stage can optionally invert both rails, which flips the logic value and the spacer polarity. The block classifies incoming words as code word, spacer or malformed, and drives idle outputs with the correct output spacer.

Parameters:
WIDTH, 8, number of dual-rail bit pairs (1..64)
DEPTH, 2, number of register stages (1..8)
INV_MASK, {DEPTH{1'b1}}, bit k=1 -> stage k inverts both rails (bit 0 = input-side stage)
IN_SP, 0, input spacer polarity: 0 = all-zero spacer (00), 1 = all-one spacer (11)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
in_t  input  WIDTH  true rails
in_f  input  WIDTH  false rails
in_valid  input  1  input word present
in_ready  output  1  block accepts the input word this cycle
out_t  output  WIDTH  true rails out
out_f  output  WIDTH  false rails out
out_valid  output  1  output word present
out_ready  input  1  downstream accepts
err  output  1  sticky malformed-input flag

Behaviour:
- Derived constant OUT_SP = IN_SP ^ (XOR-reduce of INV_MASK).
- Input classification, per pair i:
  - spacer: in_t[i]==in_f[i]==IN_SP
  - code: in_t[i]!=in_f[i]
  - illegal: in_t[i]==in_f[i]==!IN_SP
- Word classification:
  - COMPLETE: all pairs are code
  - SPACER: all pairs are spacer
  - MALFORMED: any other word, including partial or illegal pairs
- Transfer occurs when in_valid && in_ready.
  - COMPLETE: loaded into stage 0, inverted if INV_MASK[0] (inversion: t'=~t, f'=~f).
  - SPACER: consumed and discarded, no error.
  - MALFORMED: consumed and discarded; err set on the same edge and held until rst.
- Pipeline: elastic, one valid bit per stage.
  - Stage k loads from stage k-1 when stage k is empty or its contents leave this cycle; inversion per INV_MASK[k] is applied on load.
  - in_ready = !v[0] || stage 0 advancing. in_ready is combinational from out_ready through the chain. No combinational path from in_* data to out_*.
- Latency: a COMPLETE word accepted at edge n gives out_valid=1 after edge n+DEPTH-1, i.e. DEPTH cycles, when out_ready has been held high.
- Throughput: 1 word/cycle. DEPTH words are buffered under backpressure.
- Output transfer on out_valid && out_ready. out_t/out_f stay stable while out_valid && !out_ready.
- Idle output: when out_valid=0, out_t=out_f={WIDTH{OUT_SP}}, a legal output spacer.
- Simultaneous events:
  - Full pipeline with out_ready=1: accepts a new word in the same cycle.
  - Full pipeline with out_ready=0: in_ready=0 and the input is not consumed, even if it is MALFORMED. err is not set unless the word is transferred.
- Reset (asynchronous, any time, including mid-transfer):
  - All valid bits cleared, err=0, out_valid=0.
  - Stage registers set to their local spacer pattern; outputs show the OUT_SP spacer immediately.
  - Words in flight are lost.
- Reset release is synchronous to clk.

Optional Feature:
SPINV_PIPE_STAT_EN
- Defined: adds output port drop_cnt[7:0].
  - Saturating count of MALFORMED words consumed; holds at 255.
  - Reset to 0 by rst. SPACER words are not counted.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Test Plan:
Common setup: WIDTH=4, DEPTH=2, INV_MASK=2'b01, IN_SP=0, so OUT_SP=1.
- Idle after reset: out_valid=0, out_t=out_f=4'b1111, err=0, in_ready=1.
- Single word: in_t=4'b1010, in_f=4'b0101, out_ready=1 -> 2 cycles later out_valid=1, out_t=4'b0101, out_f=4'b1010; next cycle outputs return to 1111/1111.
- Backpressure: out_ready=0, send 3 COMPLETE words -> first two accepted, in_ready=0 on third. Raise out_ready -> words emerge in order, one per cycle, no loss or duplication.
- Spacer/malformed: send in_t=in_f=4'b0000 -> consumed, no output, err=0. Then send in_t=4'b1100, in_f=4'b0100 -> consumed, no output, err=1 and stays 1 (drop_cnt=1 with SPINV_PIPE_STAT_EN).
- Mid-operation reset: assert rst asynchronously with 2 words buffered -> out_valid=0 and out=1111/1111 before the next clk edge. After release, the pipeline is empty and err=0.
- Second configuration: INV_MASK=2'b11, IN_SP=1 -> idle out=1111/1111; in_t=4'b0011, in_f=4'b1100 -> out_t=4'b0011, out_f=4'b1100.
